wr_ingress_ctrl: RTL and testbench

Write-side ingress stage placed directly upstream of the async FIFO write-pointer/full logic in the `wclk` domain. Accepts words from a producer over a valid/ready handshake, holds them in a 2-entry skid buffer, and issues `winc`/`wdata` only while `wfull` is low, so the FIFO never sees a write against full. Adds drain sequencing, sticky error containment on FIFO overflow, and stall/drop statistics.

---
 rtl/wr_ingress_ctrl.sv | 123 ++++++++++++
 tb/tb_wr_ingress_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_ingress_ctrl.sv
// Write-side ingress for an async FIFO: 2-entry skid buffer, drain
// sequencing, sticky overflow containment and stall/drop statistics.
// Ports: wclk/hw_rst/sw_rst; s_valid/s_data/s_ready producer side;
// winc/wdata/wfull/wr_overflow FIFO side; drain_req/drain_done;
// err, stall_cnt, drop_cnt status.
module wr_ingress_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int STICKY_ERROR = 0,
  parameter int STALL_W      = 16,
  parameter int DROP_W       = 8
) (
  input  logic                  wclk,
  input  logic                  hw_rst,
  input  logic                  sw_rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic                  winc,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wfull,
  input  logic                  wr_overflow,
  output logic                  err,
  output logic [STALL_W-1:0]    stall_cnt,
  output logic [DROP_W-1:0]     drop_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_cnt;
  logic [STALL_W-1:0]    r_stall;
  logic [DROP_W-1:0]     r_drop;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_stall_inc;
  logic                  w_ovf_err;
  logic [DROP_W:0]       w_drop_sum;

  assign s_ready = (r_state == RUN) && (r_cnt != 2'd2)
                   && !hw_rst && !sw_rst;
  assign winc    = (r_cnt != 2'd0) && !wfull && (r_state != ERR)
                   && !hw_rst && !sw_rst;
  assign wdata   = r_mem[r_head];

  assign w_push  = s_valid && s_ready;
  assign w_pop   = winc;

  assign w_stall_inc = (r_cnt != 2'd0) && wfull
                       && (r_state != ERR);
  assign w_ovf_err   = (STICKY_ERROR != 0) && wr_overflow
                       && (r_state != ERR);

  // One spare bit catches the carry so the drop count saturates.
  assign w_drop_sum = {1'b0, r_drop} + (DROP_W+1)'(r_cnt);

  assign err        = (r_state == ERR);
  assign drain_done = (r_state == DONE);
  assign stall_cnt  = r_stall;
  assign drop_cnt   = r_drop;

  always_comb begin
    w_state_nxt = r_state;
    if (w_ovf_err) begin
      w_state_nxt = ERR;
    end else begin
      unique case (r_state)
        RUN:   if (drain_req) w_state_nxt = DRAIN;
        // Registered cnt: entering with an empty buffer costs one cycle.
        DRAIN: if (r_cnt == 2'd0) w_state_nxt = DONE;
        DONE:  if (!drain_req) w_state_nxt = RUN;
        ERR:   w_state_nxt = ERR;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge wclk) begin
    if (hw_rst) begin
      r_state  <= RUN;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_cnt    <= 2'd0;
      r_stall  <= '0;
      r_drop   <= '0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else if (sw_rst) begin
      r_state <= RUN;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_cnt   <= 2'd0;
      r_stall <= '0;
      if (w_drop_sum[DROP_W]) r_drop <= '1;
      else                    r_drop <= w_drop_sum[DROP_W-1:0];
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_mem[r_tail] <= s_data;
        r_tail        <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_stall_inc && !(&r_stall)) r_stall <= r_stall + 1'b1;
    end
  end

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Directed bench for wr_ingress_ctrl; one instance with sticky error
// enabled (a) and one with it disabled (b), sharing all inputs.
module tb_wr_ingress_ctrl;

  logic       wclk = 1'b0;
  logic       hw_rst, sw_rst, s_valid, drain_req, wfull, wr_overflow;
  logic [7:0] s_data;

  logic        s_ready_a, drain_done_a, winc_a, err_a;
  logic [7:0]  wdata_a, drop_a;
  logic [15:0] stall_a;
  logic        s_ready_b, drain_done_b, winc_b, err_b;
  logic [7:0]  wdata_b, drop_b;
  logic [15:0] stall_b;

  int ncmp = 0;
  int nerr = 0;

  always #5 wclk = ~wclk;

  wr_ingress_ctrl #(.DATA_WIDTH(8), .STICKY_ERROR(1),
                    .STALL_W(16), .DROP_W(8)) dut_a (
    .wclk(wclk), .hw_rst(hw_rst), .sw_rst(sw_rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
    .drain_req(drain_req), .drain_done(drain_done_a),
    .winc(winc_a), .wdata(wdata_a), .wfull(wfull),
    .wr_overflow(wr_overflow), .err(err_a),
    .stall_cnt(stall_a), .drop_cnt(drop_a)
  );

  wr_ingress_ctrl #(.DATA_WIDTH(8), .STICKY_ERROR(0),
                    .STALL_W(16), .DROP_W(8)) dut_b (
    .wclk(wclk), .hw_rst(hw_rst), .sw_rst(sw_rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
    .drain_req(drain_req), .drain_done(drain_done_b),
    .winc(winc_b), .wdata(wdata_b), .wfull(wfull),
    .wr_overflow(wr_overflow), .err(err_b),
    .stall_cnt(stall_b), .drop_cnt(drop_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance to mid-cycle of the next clock for checking.
  task automatic sample();
    @(negedge wclk);
  endtask

  // Cross the next rising edge; inputs change 1 unit after it.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    hw_rst = 1'b1; sw_rst = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    drain_req = 1'b0; wfull = 1'b0; wr_overflow = 1'b0;
    tick();
    sample();
    chk("rst_sready", 32'(s_ready_a), 0);
    chk("rst_winc", 32'(winc_a), 0);
    tick();
    hw_rst = 1'b0;
    sample();
    chk("rst_sready_after", 32'(s_ready_a), 1);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_done", 32'(drain_done_a), 0);
    chk("rst_stall", 32'(stall_a), 0);
    chk("rst_drop", 32'(drop_a), 0);
    chk("rst_wdata", 32'(wdata_a), 0);
    chk("rst_winc2", 32'(winc_a), 0);
    tick();

    // Streaming 0x01..0x10
    s_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_data = 8'(i);
      sample();
      chk("str_sready", 32'(s_ready_a), 1);
      if (i > 1) begin
        chk("str_winc", 32'(winc_a), 1);
        chk("str_wdata", 32'(wdata_a), 32'(i - 1));
      end
      tick();
    end
    s_valid = 1'b0;
    sample();
    chk("str_winc_last", 32'(winc_a), 1);
    chk("str_wdata_last", 32'(wdata_a), 32'h10);
    tick();
    sample();
    chk("str_idle", 32'(winc_a), 0);
    chk("str_stall", 32'(stall_a), 0);
    tick();

    // Backpressure
    s_valid = 1'b1; s_data = 8'hA1;
    sample();
    tick();
    wfull = 1'b1; s_data = 8'hA2;
    sample();
    chk("bp_winc_c1", 32'(winc_a), 0);
    chk("bp_sready_c1", 32'(s_ready_a), 1);
    tick();
    s_data = 8'hA3;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("bp_sready_full", 32'(s_ready_a), 0);
      chk("bp_winc_full", 32'(winc_a), 0);
      tick();
    end
    wfull = 1'b0;
    sample();
    chk("bp_stall", 32'(stall_a), 5);
    chk("bp_sready_c6", 32'(s_ready_a), 0);
    chk("bp_winc_a1", 32'(winc_a), 1);
    chk("bp_wdata_a1", 32'(wdata_a), 32'hA1);
    tick();
    sample();
    chk("bp_sready_c7", 32'(s_ready_a), 1);
    chk("bp_wdata_a2", 32'(wdata_a), 32'hA2);
    chk("bp_winc_a2", 32'(winc_a), 1);
    tick();
    s_valid = 1'b0;
    sample();
    chk("bp_wdata_a3", 32'(wdata_a), 32'hA3);
    chk("bp_winc_a3", 32'(winc_a), 1);
    tick();
    sample();
    chk("bp_winc_end", 32'(winc_a), 0);
    tick();

    // Drain with two words buffered
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'hB1;
    tick();
    s_data = 8'hB2;
    tick();
    s_valid = 1'b0; wfull = 1'b0; drain_req = 1'b1;
    sample();
    chk("dr_winc_b1", 32'(winc_a), 1);
    chk("dr_wdata_b1", 32'(wdata_a), 32'hB1);
    tick();
    sample();
    chk("dr_sready", 32'(s_ready_a), 0);
    chk("dr_wdata_b2", 32'(wdata_a), 32'hB2);
    chk("dr_winc_b2", 32'(winc_a), 1);
    chk("dr_done_early", 32'(drain_done_a), 0);
    tick();
    sample();
    chk("dr_winc_empty", 32'(winc_a), 0);
    chk("dr_done_wait", 32'(drain_done_a), 0);
    tick();
    sample();
    chk("dr_done", 32'(drain_done_a), 1);
    chk("dr_sready_done", 32'(s_ready_a), 0);
    tick();
    drain_req = 1'b0;
    tick();
    sample();
    chk("dr_sready_run", 32'(s_ready_a), 1);
    chk("dr_done_clr", 32'(drain_done_a), 0);
    tick();

    // Sticky error with one word buffered
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'hC1;
    tick();
    s_valid = 1'b0; wr_overflow = 1'b1;
    sample();
    chk("er_before", 32'(err_a), 0);
    tick();
    wr_overflow = 1'b0; wfull = 1'b0;
    sample();
    chk("er_err_a", 32'(err_a), 1);
    chk("er_err_b", 32'(err_b), 0);
    chk("er_winc_b", 32'(winc_b), 1);
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("er_winc_hold", 32'(winc_a), 0);
      chk("er_sready_hold", 32'(s_ready_a), 0);
      chk("er_wdata_hold", 32'(wdata_a), 32'hC1);
      tick();
    end
    sw_rst = 1'b1;
    sample();
    chk("er_sw_winc", 32'(winc_a), 0);
    chk("er_sw_sready", 32'(s_ready_a), 0);
    tick();
    sw_rst = 1'b0;
    sample();
    chk("er_clr", 32'(err_a), 0);
    chk("er_sready_run", 32'(s_ready_a), 1);
    chk("er_drop_a", 32'(drop_a), 1);
    chk("er_drop_b", 32'(drop_b), 0);
    chk("er_stall_a", 32'(stall_a), 0);
    chk("er_err_b_end", 32'(err_b), 0);
    tick();

    // Soft reset mid-burst
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'hD1;
    tick();
    s_data = 8'hD2;
    tick();
    s_valid = 1'b0; sw_rst = 1'b1;
    sample();
    chk("sr_winc", 32'(winc_a), 0);
    chk("sr_sready", 32'(s_ready_a), 0);
    tick();
    sw_rst = 1'b0; wfull = 1'b0; s_valid = 1'b1; s_data = 8'hE1;
    sample();
    chk("sr_drop_a", 32'(drop_a), 3);
    chk("sr_drop_b", 32'(drop_b), 2);
    chk("sr_stall", 32'(stall_a), 0);
    chk("sr_empty", 32'(winc_a), 0);
    chk("sr_sready", 32'(s_ready_a), 1);
    tick();
    s_valid = 1'b0;
    sample();
    chk("sr_first_winc", 32'(winc_a), 1);
    chk("sr_first_data", 32'(wdata_a), 32'hE1);
    tick();
    hw_rst = 1'b1;
    tick();
    hw_rst = 1'b0;
    sample();
    chk("hr_drop", 32'(drop_a), 0);
    chk("hr_wdata", 32'(wdata_a), 0);
    tick();

    // drain_req and wr_overflow together
    drain_req = 1'b1; wr_overflow = 1'b1;
    tick();
    wr_overflow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("sim_err", 32'(err_a), 1);
      chk("sim_done", 32'(drain_done_a), 0);
      tick();
    end
    sample();
    chk("sim_done_b", 32'(drain_done_b), 1);
    sw_rst = 1'b1; drain_req = 1'b0;
    tick();
    sw_rst = 1'b0;
    sample();
    chk("sim_exit", 32'(err_a), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
